dma_bench_engine: RTL and testbench

Executes one DMA benchmark run per 193-bit command from the benchmark controller's DMA command stream.
- Expands the command into a strided sequence of DMA read or write descriptors.
- For writes, sources the payload.
- Counts status completions and reports total execution cycles back to the controller's cycle-count readback input.
- Sits between the benchmark controller and the DMA engine descriptor/status/data channels.

---
 rtl/dma_bench_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_dma_bench_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bench_engine.sv
// Benchmark DMA engine: expands one command into strided descriptors,
// sources write payload, counts completions and times the run.
module dma_bench_engine #(
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                user_clk,
    input  logic                user_aresetn,
    input  logic                s_axis_cmd_valid,
    output logic                s_axis_cmd_ready,
    input  logic [192:0]        s_axis_cmd_data,
    output logic                m_axis_dma_cmd_valid,
    input  logic                m_axis_dma_cmd_ready,
    output logic [63:0]         m_axis_dma_cmd_addr,
    output logic [31:0]         m_axis_dma_cmd_len,
    output logic                m_axis_dma_cmd_write,
    input  logic                s_axis_dma_sts_valid,
    output logic                s_axis_dma_sts_ready,
    output logic                m_axis_wr_data_valid,
    input  logic                m_axis_wr_data_ready,
    output logic [DATA_W-1:0]   m_axis_wr_data_data,
    output logic [DATA_W/8-1:0] m_axis_wr_data_keep,
    output logic                m_axis_wr_data_last,
    output logic [63:0]         execution_cycles,
    output logic                busy
);

    localparam int BPB = DATA_W / 8;
    localparam int LB  = $clog2(BPB);
    localparam int REP = DATA_W / 32;
    localparam logic [BPB-1:0] KEEP_ONE = {{(BPB-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    logic [1:0]    rst_sync_q;
    logic          rst_n_i;

    state_t        state_q, state_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    logic          busy_q, busy_d;
    logic [47:0]   base_q, base_d;
    logic [47:0]   size_q, size_d;
    logic [31:0]   num_q, num_d;
    logic [31:0]   chunk_q, chunk_d;
    logic [31:0]   stride_q, stride_d;
    logic          is_wr_q, is_wr_d;
    logic [47:0]   offset_q, offset_d;
    logic [31:0]   issued_q, issued_d;
    logic [31:0]   completed_q, completed_d;
    logic [63:0]   cycles_q, cycles_d;
    logic [31:0]   bpc_q, bpc_d;
    logic [LB-1:0] rem_q, rem_d;
    logic [31:0]   wchunk_q, wchunk_d;
    logic [31:0]   wbeat_q, wbeat_d;
    logic [31:0]   widx_q, widx_d;

    logic          cmd_hs;
    logic          active;
    logic          dv;
    logic          d_hs;
    logic          wv;
    logic          w_hs;
    logic          w_last;
    logic          sts_take;
    logic [31:0]   outstanding;
    logic [32:0]   bpc_sum;
    logic [47:0]   off_next;
    logic [48:0]   off_end;
    logic [BPB-1:0] keep_raw;

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_i = rst_sync_q[1];

    assign active      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign cmd_hs      = cmd_rdy_q & s_axis_cmd_valid;
    assign outstanding = issued_q - completed_q;
    assign dv          = (state_q == S_ISSUE) &&
                         (outstanding < 32'(MAX_OUTSTANDING));
    assign d_hs        = dv & m_axis_dma_cmd_ready;
    assign wv          = is_wr_q && active && (wchunk_q < issued_q);
    assign w_hs        = wv & m_axis_wr_data_ready;
    assign w_last      = (wbeat_q == bpc_q - 32'd1);
    assign sts_take    = s_axis_dma_sts_valid && active &&
                         (completed_q < num_q);

    // Next-state computation for the run FSM, counters and payload generator.
    always_comb begin
        state_d     = state_q;
        cmd_rdy_d   = cmd_rdy_q;
        busy_d      = busy_q;
        base_d      = base_q;
        size_d      = size_q;
        num_d       = num_q;
        chunk_d     = chunk_q;
        stride_d    = stride_q;
        is_wr_d     = is_wr_q;
        offset_d    = offset_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        cycles_d    = cycles_q;
        bpc_d       = bpc_q;
        rem_d       = rem_q;
        wchunk_d    = wchunk_q;
        wbeat_d     = wbeat_q;
        widx_d      = widx_q;
        bpc_sum     = {1'b0, s_axis_cmd_data[159:128]} + 33'(BPB - 1);
        off_next    = offset_q + {16'h0, stride_q};
        off_end     = {1'b0, off_next} + {17'h0, chunk_q};

        unique case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    base_d      = s_axis_cmd_data[47:0];
                    size_d      = s_axis_cmd_data[95:48];
                    num_d       = s_axis_cmd_data[127:96];
                    chunk_d     = s_axis_cmd_data[159:128];
                    stride_d    = s_axis_cmd_data[191:160];
                    is_wr_d     = s_axis_cmd_data[192];
                    bpc_d       = 32'(bpc_sum >> LB);
                    rem_d       = s_axis_cmd_data[128 +: LB];
                    offset_d    = '0;
                    issued_d    = '0;
                    completed_d = '0;
                    cycles_d    = '0;
                    wchunk_d    = '0;
                    wbeat_d     = '0;
                    widx_d      = '0;
                    busy_d      = 1'b1;
                    if (s_axis_cmd_data[127:96] == 32'd0 ||
                        s_axis_cmd_data[159:128] == 32'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (d_hs) begin
                    issued_d = issued_q + 32'd1;
                    if (off_end > {1'b0, size_q}) begin
                        offset_d = '0;
                    end else begin
                        offset_d = off_next;
                    end
                    if (issued_q + 32'd1 == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (completed_q == num_q &&
                    (!is_wr_q || wchunk_q == num_q)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (active) begin
            cycles_d = cycles_q + 64'd1;
        end
        if (sts_take) begin
            completed_d = completed_q + 32'd1;
        end
        if (w_hs) begin
            widx_d = widx_q + 32'd1;
            if (w_last) begin
                wbeat_d  = '0;
                wchunk_d = wchunk_q + 32'd1;
            end else begin
                wbeat_d  = wbeat_q + 32'd1;
            end
        end
        cmd_rdy_d = (state_d == S_IDLE);
    end

    // Register all state; async reset returns the engine to IDLE.
    always_ff @(posedge user_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            base_q      <= '0;
            size_q      <= '0;
            num_q       <= '0;
            chunk_q     <= '0;
            stride_q    <= '0;
            is_wr_q     <= 1'b0;
            offset_q    <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            cycles_q    <= '0;
            bpc_q       <= '0;
            rem_q       <= '0;
            wchunk_q    <= '0;
            wbeat_q     <= '0;
            widx_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_rdy_q   <= cmd_rdy_d;
            busy_q      <= busy_d;
            base_q      <= base_d;
            size_q      <= size_d;
            num_q       <= num_d;
            chunk_q     <= chunk_d;
            stride_q    <= stride_d;
            is_wr_q     <= is_wr_d;
            offset_q    <= offset_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            cycles_q    <= cycles_d;
            bpc_q       <= bpc_d;
            rem_q       <= rem_d;
            wchunk_q    <= wchunk_d;
            wbeat_q     <= wbeat_d;
            widx_q      <= widx_d;
        end
    end

    // Trailing beat keeps only the bytes actually in the chunk.
    always_comb begin
        keep_raw = '1;
        if (w_last && rem_q != '0) begin
            keep_raw = (KEEP_ONE << rem_q) - KEEP_ONE;
        end
    end

    assign s_axis_cmd_ready     = cmd_rdy_q;
    assign m_axis_dma_cmd_valid = dv;
    assign m_axis_dma_cmd_addr  = {16'h0, base_q + offset_q};
    assign m_axis_dma_cmd_len   = chunk_q;
    assign m_axis_dma_cmd_write = is_wr_q;
    assign s_axis_dma_sts_ready = 1'b1;
    assign m_axis_wr_data_valid = wv;
    assign m_axis_wr_data_data  = wv ? {REP{widx_q}} : '0;
    assign m_axis_wr_data_keep  = wv ? keep_raw : '0;
    assign m_axis_wr_data_last  = wv & w_last;
    assign execution_cycles     = cycles_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_dma_bench_engine.sv
// Scoreboard bench for dma_bench_engine: a reference model queues
// expected descriptors and beats, monitors pop and compare.
module tb_dma_bench_engine;

    localparam int DW  = 512;
    localparam int BPB = DW / 8;
    localparam int MO  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [192:0]    cmd_data = '0;
    logic            dcmd_valid;
    logic            dcmd_ready = 1'b0;
    logic [63:0]     dcmd_addr;
    logic [31:0]     dcmd_len;
    logic            dcmd_write;
    logic            sts_valid = 1'b0;
    logic            sts_ready;
    logic            wr_valid;
    logic            wr_ready = 1'b0;
    logic [DW-1:0]   wr_data;
    logic [BPB-1:0]  wr_keep;
    logic            wr_last;
    logic [63:0]     exec_cycles;
    logic            busy;

    always #5 clk = ~clk;

    dma_bench_engine #(
        .DATA_W(DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .user_clk(clk),
        .user_aresetn(rst_n),
        .s_axis_cmd_valid(cmd_valid),
        .s_axis_cmd_ready(cmd_ready),
        .s_axis_cmd_data(cmd_data),
        .m_axis_dma_cmd_valid(dcmd_valid),
        .m_axis_dma_cmd_ready(dcmd_ready),
        .m_axis_dma_cmd_addr(dcmd_addr),
        .m_axis_dma_cmd_len(dcmd_len),
        .m_axis_dma_cmd_write(dcmd_write),
        .s_axis_dma_sts_valid(sts_valid),
        .s_axis_dma_sts_ready(sts_ready),
        .m_axis_wr_data_valid(wr_valid),
        .m_axis_wr_data_ready(wr_ready),
        .m_axis_wr_data_data(wr_data),
        .m_axis_wr_data_keep(wr_keep),
        .m_axis_wr_data_last(wr_last),
        .execution_cycles(exec_cycles),
        .busy(busy)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        logic        wr;
    } desc_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic [BPB-1:0] keep;
        logic           last;
        int             chunk;
    } beat_t;

    desc_t exp_d[$];
    beat_t exp_b[$];

    int checks = 0;
    int fails = 0;
    int desc_total = 0;
    int sts_sent = 0;
    int busy_total = 0;
    int busy_base = 0;
    int run_desc_base = 0;
    int rdy_pct = 100;
    int sts_pct = 100;
    int sts_hold = 0;
    int release_cnt = 0;

    function automatic void chk(input bit ok, input string nm,
                                input logic [DW-1:0] act,
                                input logic [DW-1:0] req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    // Random backpressure on descriptor and payload channels.
    always @(posedge clk) begin
        #1;
        dcmd_ready = ($urandom % 100) < rdy_pct;
        wr_ready   = ($urandom % 100) < rdy_pct;
    end

    // One completion per handshaken descriptor, optionally withheld.
    always @(posedge clk) begin
        #1;
        if ((desc_total - sts_sent) > 0 &&
            (sts_hold == 0 || release_cnt > 0) &&
            ($urandom % 100) < sts_pct) begin
            sts_valid = 1'b1;
            sts_sent++;
            if (sts_hold != 0) release_cnt--;
        end else begin
            sts_valid = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_total++;
            if (wr_valid && wr_ready) begin
                if (exp_b.size() == 0) begin
                    chk(1'b0, "beat_unexpected", DW'(wr_keep), '0);
                end else begin
                    beat_t b;
                    b = exp_b.pop_front();
                    chk(wr_data == b.data, "beat_data", wr_data, b.data);
                    chk(wr_keep == b.keep, "beat_keep",
                        DW'(wr_keep), DW'(b.keep));
                    chk(wr_last == b.last, "beat_last",
                        DW'(wr_last), DW'(b.last));
                    chk((desc_total - run_desc_base) > b.chunk,
                        "beat_before_desc",
                        DW'(desc_total - run_desc_base), DW'(b.chunk + 1));
                end
            end
            if (dcmd_valid && dcmd_ready) begin
                if (exp_d.size() == 0) begin
                    chk(1'b0, "desc_unexpected", DW'(dcmd_addr), '0);
                end else begin
                    desc_t d;
                    d = exp_d.pop_front();
                    chk(dcmd_addr == d.addr, "desc_addr",
                        DW'(dcmd_addr), DW'(d.addr));
                    chk(dcmd_len == d.len, "desc_len",
                        DW'(dcmd_len), DW'(d.len));
                    chk(dcmd_write == d.wr, "desc_write",
                        DW'(dcmd_write), DW'(d.wr));
                end
                desc_total++;
            end
        end
    end

    task automatic start_cmd(input logic [47:0] base,
                             input logic [47:0] size,
                             input logic [31:0] n,
                             input logic [31:0] chunk,
                             input logic [31:0] stride,
                             input logic wr);
        longint off;
        longint nxt;
        longint nb;
        logic [31:0] idx;
        bit got;
        off = 0;
        idx = 0;
        if (chunk != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                desc_t d;
                d.addr = {16'h0, 48'(longint'(base) + off)};
                d.len  = chunk;
                d.wr   = wr;
                exp_d.push_back(d);
                if (wr) begin
                    nb = (longint'(chunk) + BPB - 1) / BPB;
                    for (longint k = 0; k < nb; k++) begin
                        beat_t b;
                        b.data  = {(DW / 32){idx}};
                        b.keep  = '1;
                        b.last  = (k == nb - 1);
                        b.chunk = i;
                        if (k == nb - 1 && (chunk % BPB) != 0)
                            b.keep = (BPB'(1) << (chunk % BPB)) - BPB'(1);
                        exp_b.push_back(b);
                        idx++;
                    end
                end
                nxt = off + longint'(stride);
                if (nxt + longint'(chunk) > longint'(size)) off = 0;
                else off = nxt;
            end
        end
        @(posedge clk);
        #1;
        run_desc_base = desc_total;
        cmd_data  = {wr, stride, chunk, n, size, base};
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        chk(got, "cmd_accept_timeout", DW'(got), DW'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        busy_base = busy_total;
    endtask

    task automatic wait_done(input bit empty);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 20000 && !done; t++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk(done, "run_timeout", DW'(done), DW'(1));
        if (empty) begin
            chk(exec_cycles == 0, "empty_exec", DW'(exec_cycles), '0);
            chk(busy_total - busy_base == 1, "empty_busy_len",
                DW'(busy_total - busy_base), DW'(1));
        end else begin
            chk(exec_cycles == 64'(busy_total - busy_base), "exec_cycles",
                DW'(exec_cycles), DW'(busy_total - busy_base));
        end
        chk(exp_d.size() == 0, "desc_left", DW'(exp_d.size()), '0);
        chk(exp_b.size() == 0, "beat_left", DW'(exp_b.size()), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(cmd_ready == 0, {tag, "_cmd_ready"}, DW'(cmd_ready), '0);
        chk(dcmd_valid == 0, {tag, "_dcmd_valid"}, DW'(dcmd_valid), '0);
        chk(dcmd_addr == 0, {tag, "_dcmd_addr"}, DW'(dcmd_addr), '0);
        chk(dcmd_len == 0, {tag, "_dcmd_len"}, DW'(dcmd_len), '0);
        chk(dcmd_write == 0, {tag, "_dcmd_write"}, DW'(dcmd_write), '0);
        chk(wr_valid == 0, {tag, "_wr_valid"}, DW'(wr_valid), '0);
        chk(wr_data == 0, {tag, "_wr_data"}, wr_data, '0);
        chk(wr_keep == 0, {tag, "_wr_keep"}, DW'(wr_keep), '0);
        chk(wr_last == 0, {tag, "_wr_last"}, DW'(wr_last), '0);
        chk(exec_cycles == 0, {tag, "_exec"}, DW'(exec_cycles), '0);
        chk(busy == 0, {tag, "_busy"}, DW'(busy), '0);
        chk(sts_ready == 1, {tag, "_sts_ready"}, DW'(sts_ready), DW'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential read addressing.
        start_cmd(48'h1000, 48'h10000, 4, 64, 128, 1'b0);
        wait_done(1'b0);
        chk(exec_cycles > 0, "read_exec_nonzero", DW'(exec_cycles), DW'(1));

        // Offset wrap at memory size.
        start_cmd(48'h0, 48'd256, 4, 64, 128, 1'b0);
        wait_done(1'b0);

        // Write with partial trailing beat.
        start_cmd(48'h4000, 48'h10000, 2, 100, 256, 1'b1);
        wait_done(1'b0);

        // Empty runs.
        start_cmd(48'h100, 48'h1000, 0, 64, 64, 1'b0);
        wait_done(1'b1);
        start_cmd(48'h100, 48'h1000, 3, 0, 64, 1'b1);
        wait_done(1'b1);

        // Outstanding limit.
        sts_hold = 1;
        start_cmd(48'h8000, 48'h100000, 20, 64, 64, 1'b0);
        repeat (60) @(negedge clk);
        chk(desc_total - run_desc_base == MO, "outstanding_cap",
            DW'(desc_total - run_desc_base), DW'(MO));
        release_cnt = 1;
        repeat (60) @(negedge clk);
        chk(desc_total - run_desc_base == MO + 1, "outstanding_release",
            DW'(desc_total - run_desc_base), DW'(MO + 1));
        sts_hold = 0;
        wait_done(1'b0);

        // Reset with three descriptors outstanding.
        sts_hold = 1;
        release_cnt = 0;
        start_cmd(48'h2000, 48'h100000, 20, 64, 64, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (desc_total - run_desc_base >= 3) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        chk(desc_total - run_desc_base == 3, "midrun_issued",
            DW'(desc_total - run_desc_base), DW'(3));
        exp_d.delete();
        exp_b.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sts_hold = 0;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (desc_total == sts_sent) ok = 1'b1;
        end
        chk(ok, "late_sts_drain", DW'(ok), DW'(1));
        chk(busy == 0, "late_sts_busy", DW'(busy), '0);
        start_cmd(48'h3000, 48'h10000, 3, 64, 64, 1'b1);
        wait_done(1'b0);

        // Randomised runs under backpressure.
        rdy_pct = 60;
        sts_pct = 50;
        for (int r = 0; r < 8; r++) begin
            start_cmd(48'($urandom & 32'hFFFFF),
                      48'($urandom_range(0, 2048)),
                      32'($urandom_range(1, 12)),
                      32'($urandom_range(1, 300)),
                      32'($urandom_range(0, 512)),
                      1'($urandom & 1));
            wait_done(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
